// File: rtl/md_unit_if.sv
// Handshake and data bundle between the EXECUTE stage and the multiply/divide unit.
interface md_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Cancel;
    logic             WriteHi;
    logic             WriteLo;
    logic [WIDTH-1:0] WriteValue;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;

    modport master (
        output Start, Op, SrcA, SrcB, Cancel, WriteHi, WriteLo, WriteValue,
        input  Busy, Done, HiOut, LoOut
    );

    modport slave (
        input  Start, Op, SrcA, SrcB, Cancel, WriteHi, WriteLo, WriteValue,
        output Busy, Done, HiOut, LoOut
    );
endinterface

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one iteration per cycle.
// Define MD_DIV_EN to build the restoring divider; without it only MULT/MULTU are accepted.
module md_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic      CLK,
    input logic      RST,
    md_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             finish;
    logic             start_ok;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic             neg_lo;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] hi_acc;
    logic [WIDTH-1:0] lo_acc;
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    // Operand magnitudes and sign flags for the signed ops.
    assign signed_op = ~bus.Op[0];
    assign a_neg     = signed_op & bus.SrcA[WIDTH-1];
    assign b_neg     = signed_op & bus.SrcB[WIDTH-1];
    assign a_abs     = a_neg ? (~bus.SrcA + WIDTH'(1)) : bus.SrcA;
    assign b_abs     = b_neg ? (~bus.SrcB + WIDTH'(1)) : bus.SrcB;

    // Shift-add step: multiplier sits in lo_acc and is consumed LSB first.
    assign mul_sum  = {1'b0, hi_acc} + ({1'b0, a_mag} & {(WIDTH + 1){lo_acc[0]}});
    assign prod     = {hi_acc, lo_acc};
    assign prod_fix = neg_lo ? (~prod + PW'(1)) : prod;

`ifdef MD_DIV_EN
    logic             is_div;
    logic             neg_hi;
    logic             div_zero;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_fits;

    assign start_ok  = 1'b1;
    // Restoring step: the partial remainder never exceeds the divisor, so W bits of difference suffice.
    assign div_shift = {hi_acc, lo_acc[WIDTH-1]};
    assign div_diff  = div_shift[WIDTH-1:0] - b_mag;
    assign div_fits  = (div_shift >= {1'b0, b_mag});
`else
    assign start_ok  = ~bus.Op[1];
`endif

    // Per-iteration next values and final sign-corrected results.
    always_comb begin
        hi_step = mul_sum[WIDTH:1];
        lo_step = {mul_sum[0], lo_acc[WIDTH-1:1]};
        hi_fix  = prod_fix[PW-1:WIDTH];
        lo_fix  = prod_fix[WIDTH-1:0];
`ifdef MD_DIV_EN
        if (is_div) begin
            hi_step = div_fits ? div_diff : div_shift[WIDTH-1:0];
            lo_step = {lo_acc[WIDTH-2:0], div_fits};
            if (div_zero) begin
                hi_fix = a_raw;
                lo_fix = '1;
            end else begin
                hi_fix = neg_hi ? (~hi_acc + WIDTH'(1)) : hi_acc;
                lo_fix = neg_lo ? (~lo_acc + WIDTH'(1)) : lo_acc;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start && !bus.Cancel && start_ok) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (bus.Cancel) begin
                    state_next = IDLE;
                end else if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                finish     = ~bus.Cancel;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            neg_lo <= 1'b0;
            hi_reg <= '0;
            lo_reg <= '0;
            a_mag  <= '0;
            hi_acc <= '0;
            lo_acc <= '0;
`ifdef MD_DIV_EN
            is_div   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            b_mag    <= '0;
            a_raw    <= '0;
`endif
        end else begin
            busy <= (state_next != IDLE);
            done <= finish;
            // MTHI/MTLO only land while idle; the hazard unit stalls them otherwise.
            if (state == IDLE) begin
                if (bus.WriteHi) hi_reg <= bus.WriteValue;
                if (bus.WriteLo) lo_reg <= bus.WriteValue;
            end
            if (accept) begin
                count  <= CW'(WIDTH - 1);
                neg_lo <= a_neg ^ b_neg;
                a_mag  <= a_abs;
                hi_acc <= '0;
                lo_acc <= b_abs;
`ifdef MD_DIV_EN
                is_div   <= bus.Op[1];
                neg_hi   <= a_neg;
                div_zero <= (bus.SrcB == '0);
                b_mag    <= b_abs;
                a_raw    <= bus.SrcA;
                if (bus.Op[1]) lo_acc <= a_abs;
`endif
            end else if (state == CALC) begin
                count  <= count - CW'(1);
                hi_acc <= hi_step;
                lo_acc <= lo_step;
            end
            if (finish) begin
                hi_reg <= hi_fix;
                lo_reg <= lo_fix;
            end
        end
    end

    assign bus.Busy  = busy;
    assign bus.Done  = done;
    assign bus.HiOut = hi_reg;
    assign bus.LoOut = lo_reg;
endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit: reset, MTHI/MTLO, multiply/divide results, latency, cancel.
module tb_md_unit;
    localparam int unsigned WIDTH = 32;

    logic CLK;
    logic RST;
    int   n_vec;
    int   n_err;

    md_unit_if #(.WIDTH(WIDTH)) bus ();

    md_unit #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one op, optionally poke a second Start before edge poke_edge, and measure latency to Done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_edge, output int lat);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        tick();
        bus.Start = 1'b0;
        check_eq("busy_after_start", {63'd0, bus.Busy}, 64'd1);
        check_eq("done_single_cycle", {63'd0, bus.Done}, 64'd0);
        lat = -1;
        for (int e = 1; e <= 60; e++) begin
            if (e == poke_edge) begin
                bus.Start = 1'b1;
                bus.Op    = 2'b01;
                bus.SrcA  = 32'h0000_1234;
                bus.SrcB  = 32'h0000_5678;
            end
            tick();
            bus.Start = 1'b0;
            if (bus.Done) begin
                lat = e;
                break;
            end
        end
        check_eq("latency", 64'(lat), 64'(WIDTH + 1));
        check_eq("busy_at_done", {63'd0, bus.Busy}, 64'd0);
    endtask

    task automatic op_vec(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        run_op(op, a, b, 0, lat);
        check_eq({tag, "_hi"}, {32'd0, bus.HiOut}, {32'd0, exp_hi});
        check_eq({tag, "_lo"}, {32'd0, bus.LoOut}, {32'd0, exp_lo});
    endtask

    initial begin
        int lat;
        int done_seen;
        int busy_seen;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;

        n_vec = 0;
        n_err = 0;
        RST            = 1'b0;
        bus.Start      = 1'b0;
        bus.Op         = 2'b00;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        bus.Cancel     = 1'b0;
        bus.WriteHi    = 1'b0;
        bus.WriteLo    = 1'b0;
        bus.WriteValue = '0;

        tick();
        tick();
        check_eq("rst_busy", {63'd0, bus.Busy}, 64'd0);
        check_eq("rst_done", {63'd0, bus.Done}, 64'd0);
        check_eq("rst_hi", {32'd0, bus.HiOut}, 64'd0);
        check_eq("rst_lo", {32'd0, bus.LoOut}, 64'd0);

        // MTHI/MTLO, together and separately.
        RST            = 1'b1;
        bus.WriteHi    = 1'b1;
        bus.WriteLo    = 1'b1;
        bus.WriteValue = 32'h55AA_55AA;
        tick();
        check_eq("mt_both_hi", {32'd0, bus.HiOut}, 64'h55AA_55AA);
        check_eq("mt_both_lo", {32'd0, bus.LoOut}, 64'h55AA_55AA);
        bus.WriteLo    = 1'b0;
        bus.WriteValue = 32'h1234_5678;
        tick();
        bus.WriteHi    = 1'b0;
        bus.WriteLo    = 1'b1;
        bus.WriteValue = 32'h9ABC_DEF0;
        tick();
        bus.WriteLo    = 1'b0;
        check_eq("mthi", {32'd0, bus.HiOut}, 64'h1234_5678);
        check_eq("mtlo", {32'd0, bus.LoOut}, 64'h9ABC_DEF0);

        op_vec("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        // Issued in the Done cycle of the previous op; a stray Start before edge 10 must be ignored.
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 10, lat);
        check_eq("mult_neg_hi", {32'd0, bus.HiOut}, 64'hFFFF_FFFF);
        check_eq("mult_neg_lo", {32'd0, bus.LoOut}, 64'hFFFF_FFF1);

        op_vec("multu_2_16", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        op_vec("mult_m1_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        op_vec("mult_pos", 2'b00, 32'h7FFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE);
        op_vec("multu_zero", 2'b01, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000);

`ifdef MD_DIV_EN
        op_vec("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_vec("divu_by0", 2'b11, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF);
        op_vec("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        op_vec("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        op_vec("div_by0_neg", 2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
`else
        // Without the divider a DIV Start is dropped entirely.
        tick();
        prev_hi   = bus.HiOut;
        prev_lo   = bus.LoOut;
        bus.Start = 1'b1;
        bus.Op    = 2'b10;
        bus.SrcA  = 32'hFFFF_FFF9;
        bus.SrcB  = 32'h0000_0002;
        busy_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            bus.Start = 1'b0;
            if (bus.Busy) busy_seen++;
            if (bus.Done) done_seen++;
        end
        check_eq("nodiv_busy", 64'(busy_seen), 64'd0);
        check_eq("nodiv_done", 64'(done_seen), 64'd0);
        check_eq("nodiv_hi", {32'd0, bus.HiOut}, {32'd0, prev_hi});
        check_eq("nodiv_lo", {32'd0, bus.LoOut}, {32'd0, prev_lo});
`endif

        // Cancel at iteration 10; an MTHI/MTLO while busy must also be ignored.
        tick();
        prev_hi   = bus.HiOut;
        prev_lo   = bus.LoOut;
        bus.Start = 1'b1;
        bus.Op    = 2'b01;
        bus.SrcA  = 32'h0000_0003;
        bus.SrcB  = 32'h0000_0004;
        tick();
        bus.Start = 1'b0;
        for (int e = 1; e < 10; e++) begin
            bus.WriteHi    = (e == 5);
            bus.WriteLo    = (e == 5);
            bus.WriteValue = 32'hDEAD_BEEF;
            tick();
        end
        bus.WriteHi = 1'b0;
        bus.WriteLo = 1'b0;
        check_eq("busy_before_cancel", {63'd0, bus.Busy}, 64'd1);
        bus.Cancel = 1'b1;
        tick();
        bus.Cancel = 1'b0;
        check_eq("cancel_busy", {63'd0, bus.Busy}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.Done) done_seen++;
        end
        check_eq("cancel_no_done", 64'(done_seen), 64'd0);
        check_eq("cancel_hi", {32'd0, bus.HiOut}, {32'd0, prev_hi});
        check_eq("cancel_lo", {32'd0, bus.LoOut}, {32'd0, prev_lo});

        // Reset at iteration 10 discards the op and clears HI/LO.
        bus.Start = 1'b1;
        bus.Op    = 2'b00;
        bus.SrcA  = 32'h0000_0007;
        bus.SrcB  = 32'h0000_0009;
        tick();
        bus.Start = 1'b0;
        for (int e = 1; e < 10; e++) tick();
        RST = 1'b0;
        tick();
        check_eq("midrst_busy", {63'd0, bus.Busy}, 64'd0);
        check_eq("midrst_done", {63'd0, bus.Done}, 64'd0);
        check_eq("midrst_hi", {32'd0, bus.HiOut}, 64'd0);
        check_eq("midrst_lo", {32'd0, bus.LoOut}, 64'd0);
        RST = 1'b1;
        tick();
        op_vec("post_rst", 2'b00, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000, 32'h0000_003F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
